// File: rtl/char_pkg.sv
// Shared glyph geometry, address/alpha helpers and the writer state enum.
// Used by both the font writer and the glyph reader so the RAM layout stays
// consistent between them.
package char_pkg;

    localparam int GLYPH_ROWS    = 8;
    localparam int GLYPH_COLS    = 8;
    localparam int ALPHA_W       = 3;
    localparam int CHAR_W        = 8;
    localparam int FONT_ADDR_W   = 14;
    localparam int BYTES_PER_ROW = 3;

    localparam int ROW_W  = $clog2(GLYPH_ROWS);
    localparam int COL_W  = $clog2(GLYPH_COLS);
    localparam int WORD_W = 8 * BYTES_PER_ROW;
    localparam int BCNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
    } fw_state_t;

    // Glyph RAM address layout: {char, row, column}.
    function automatic logic [FONT_ADDR_W-1:0] font_addr(
        input logic [CHAR_W-1:0] c,
        input logic [ROW_W-1:0]  r,
        input logic [COL_W-1:0]  k
    );
        return {c, r, k};
    endfunction

    // Alpha for column k sits in bits [3k+2:3k] of the packed row word.
    function automatic logic [ALPHA_W-1:0] alpha_of(
        input logic [WORD_W-1:0] w,
        input logic [COL_W-1:0]  k
    );
        logic [4:0] lsb;
        lsb = 5'(k) * 5'd3;
        return w[lsb +: ALPHA_W];
    endfunction

endpackage

// File: rtl/font_writer_if.sv
// Byte-stream input and glyph-RAM write port of the font writer.
// master: the producer/testbench side; slave: the font writer itself.
interface font_writer_if;
    import char_pkg::*;

    logic                   i_start;
    logic [CHAR_W-1:0]      i_char;
    logic [7:0]             i_data;
    logic                   i_valid;
    logic                   o_ready;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_we;
    logic [FONT_ADDR_W-1:0] o_addr;
    logic [ALPHA_W-1:0]     o_alpha;

    modport master (
        output i_start, i_char, i_data, i_valid,
        input  o_ready, o_busy, o_done, o_we, o_addr, o_alpha
    );

    modport slave (
        input  i_start, i_char, i_data, i_valid,
        output o_ready, o_busy, o_done, o_we, o_addr, o_alpha
    );

endinterface

// File: rtl/font_writer.sv
// Font writer: unpacks three little-endian bytes per glyph row into eight
// 3-bit alpha values and writes them to the glyph RAM, one per cycle.
// Build option FONT_WRITER_AUTOINC_EN: when defined, finishing row 7 moves
// on to the next character code (wrapping 0xFF -> 0x00) and keeps
// collecting; when undefined, the writer returns to IDLE after each glyph.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for i_start; o_ready low
// ST_COLLECT | accepting the 3 packed bytes of the current row
// ST_WRITE   | emitting 8 consecutive alpha writes for the current row
module font_writer
    import char_pkg::*;
(
    input logic          i_clk,
    input logic          i_rst,
    font_writer_if.slave bus
);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(GLYPH_ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(GLYPH_COLS - 1);

    fw_state_t              state;
    logic [CHAR_W-1:0]      ch;
    logic [ROW_W-1:0]       row;
    logic [COL_W-1:0]       col;
    logic [BCNT_W-1:0]      bcnt;
    logic [WORD_W-1:0]      word;

    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   we_q;
    logic [FONT_ADDR_W-1:0] addr_q;
    logic [ALPHA_W-1:0]     alpha_q;

    assign bus.o_ready = ready_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_we    = we_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_alpha = alpha_q;

    // Sequencer: state, counters, row word and all registered outputs.
    // Outputs are computed one cycle ahead so the first write of a row
    // appears in the cycle right after its third byte is accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            ch      <= '0;
            row     <= '0;
            col     <= '0;
            bcnt    <= '0;
            word    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            alpha_q <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            if (bus.i_start) begin
                // Start always wins: aborts any glyph in flight and drops a
                // byte offered in the same cycle.
                state   <= ST_COLLECT;
                ch      <= bus.i_char;
                row     <= '0;
                col     <= '0;
                bcnt    <= '0;
                word    <= '0;
                ready_q <= 1'b1;
                busy_q  <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    ST_COLLECT: begin
                        if (bus.i_valid) begin
                            unique case (bcnt)
                                2'd0:    word[7:0]   <= bus.i_data;
                                2'd1:    word[15:8]  <= bus.i_data;
                                default: word[23:16] <= bus.i_data;
                            endcase
                            if (bcnt == LAST_BYTE) begin
                                // Column 0 only needs byte0, already in word.
                                bcnt    <= '0;
                                col     <= '0;
                                state   <= ST_WRITE;
                                ready_q <= 1'b0;
                                we_q    <= 1'b1;
                                addr_q  <= font_addr(ch, row, '0);
                                alpha_q <= alpha_of(word, '0);
                            end else begin
                                bcnt <= bcnt + 2'd1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (col != LAST_COL) begin
                            col     <= col + 3'd1;
                            we_q    <= 1'b1;
                            addr_q  <= font_addr(ch, row, col + 3'd1);
                            alpha_q <= alpha_of(word, col + 3'd1);
                        end else begin
                            col  <= '0;
                            word <= '0;
                            if (row != LAST_ROW) begin
                                row     <= row + 3'd1;
                                state   <= ST_COLLECT;
                                ready_q <= 1'b1;
                            end else begin
                                done_q <= 1'b1;
                                row    <= '0;
`ifdef FONT_WRITER_AUTOINC_EN
                                ch      <= ch + 8'd1;
                                state   <= ST_COLLECT;
                                ready_q <= 1'b1;
`else
                                state   <= ST_IDLE;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
`endif
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_font_writer.sv
// Self-checking bench for font_writer: directed glyph scenarios followed by
// randomized start/valid/reset traffic. A transaction-level model predicts
// the write stream and per-cycle status; a monitor compares at negedge.
module tb_font_writer;
    import char_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    font_writer_if bus();

    font_writer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [13:0] addr;
        logic [2:0]  alpha;
    } wr_t;

    typedef struct {
        int cyc;
        bit ready;
        bit busy;
        bit we;
        bit done;
    } st_t;

    wr_t exp_wr[$];
    st_t exp_st[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A glyph in progress is: target char, current row, bytes gathered so
    // far, and a list of writes still to be emitted (one per cycle).
    bit  m_active = 0;
    int  m_char   = 0;
    int  m_row    = 0;
    bit  m_done   = 0;
    int  m_bytes[$];
    wr_t m_pend[$];

    task automatic model_update(input bit r, input bit s, input int ch,
                                input bit v, input int d);
        bit rdy;
        int w;
        wr_t e;
        rdy    = m_active && (m_pend.size() == 0);
        m_done = 0;
        if (r) begin
            m_active = 0;
            m_char   = 0;
            m_row    = 0;
            m_bytes.delete();
            m_pend.delete();
        end else if (s) begin
            m_active = 1;
            m_char   = ch;
            m_row    = 0;
            m_bytes.delete();
            m_pend.delete();
        end else if (m_pend.size() != 0) begin
            void'(m_pend.pop_front());
            if (m_pend.size() == 0) begin
                if (m_row < GLYPH_ROWS - 1) begin
                    m_row++;
                end else begin
                    m_done = 1;
                    m_row  = 0;
`ifdef FONT_WRITER_AUTOINC_EN
                    m_char = (m_char + 1) % 256;
`else
                    m_active = 0;
`endif
                end
            end
        end else if (rdy && v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == BYTES_PER_ROW) begin
                w = m_bytes[0] + m_bytes[1] * 256 + m_bytes[2] * 65536;
                for (int c = 0; c < GLYPH_COLS; c++) begin
                    e.cyc   = 0;
                    e.addr  = 14'(m_char * 64 + m_row * 8 + c);
                    e.alpha = 3'((w >> (3 * c)) & 7);
                    m_pend.push_back(e);
                end
                m_bytes.delete();
            end
        end
    endtask

    // One clock cycle: drive inputs, record what the outputs must be this
    // cycle, advance the model, then move to just after the next edge.
    task automatic step(input bit r, input bit s, input int ch,
                        input bit v, input int d);
        st_t st;
        wr_t w;
        rst         = r;
        bus.i_start = s;
        bus.i_char  = 8'(ch);
        bus.i_valid = v;
        bus.i_data  = 8'(d);
        st.cyc   = cyc;
        st.ready = m_active && (m_pend.size() == 0);
        st.busy  = m_active;
        st.we    = (m_pend.size() != 0);
        st.done  = m_done;
        exp_st.push_back(st);
        if (m_pend.size() != 0) begin
            w     = m_pend[0];
            w.cyc = cyc;
            exp_wr.push_back(w);
        end
        model_update(r, s, ch, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic send(input int d);
        step(0, 0, 0, 1, d);
    endtask

    // ---------------- monitor ----------------
    st_t mon_st;
    wr_t mon_wr;
    always @(negedge clk) begin
        if (exp_st.size() != 0) begin
            mon_st = exp_st.pop_front();
            chk("ready", 32'(bus.o_ready), 32'(mon_st.ready));
            chk("busy",  32'(bus.o_busy),  32'(mon_st.busy));
            chk("we",    32'(bus.o_we),    32'(mon_st.we));
            chk("done",  32'(bus.o_done),  32'(mon_st.done));
        end
        if (bus.o_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write @cyc %0d: got addr %0h alpha %0h expected none",
                         cyc, bus.o_addr, bus.o_alpha);
            end else begin
                mon_wr = exp_wr.pop_front();
                chk("write_cycle", 32'(cyc), 32'(mon_wr.cyc));
                chk("addr",  32'(bus.o_addr),  32'(mon_wr.addr));
                chk("alpha", 32'(bus.o_alpha), 32'(mon_wr.alpha));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.i_start = 1'b0;
        bus.i_char  = 8'h00;
        bus.i_valid = 1'b1;
        bus.i_data  = 8'hAA;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_busy",  32'(bus.o_busy),  32'd0);
        chk("rst_done",  32'(bus.o_done),  32'd0);
        chk("rst_we",    32'(bus.o_we),    32'd0);
        chk("rst_addr",  32'(bus.o_addr),  32'd0);
        chk("rst_alpha", 32'(bus.o_alpha), 32'd0);

        // valid without start is ignored in IDLE
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8'h5A);

        // char 0x41, all-ones row: 0x1040..0x1047, alpha 7
        step(0, 1, 8'h41, 0, 0);
        send(8'hFF); send(8'hFF); send(8'hFF);
        idle(12);

        // char 0x00, ramp row: alpha 0..7
        step(0, 1, 8'h00, 0, 0);
        send(8'h88); send(8'hC6); send(8'hFA);
        idle(12);

        // char 0xFF full glyph, then three more bytes (autoinc wraps to 0x00)
        step(0, 1, 8'hFF, 0, 0);
        for (int r = 0; r < GLYPH_ROWS; r++) begin
            for (int b = 0; b < BYTES_PER_ROW; b++) send($urandom_range(0, 255));
            idle(10);
        end
        send(8'h12); send(8'h34); send(8'h56);
        idle(12);

        // abort mid-row with a byte offered in the same cycle as start
        step(0, 1, 8'h10, 0, 0);
        send(8'h11); send(8'h22);
        step(0, 1, 8'h20, 1, 8'h55);
        send(8'hA1); send(8'hB2); send(8'hC3);
        idle(12);

        // reset during the third write of a row
        step(0, 1, 8'h33, 0, 0);
        send(8'h9C); send(8'h3E); send(8'h71);
        idle(2);
        step(1, 0, 0, 0, 0);
        idle(12);

        // valid offered during the write phase must be ignored
        step(0, 1, 8'h7E, 0, 0);
        send(8'h01); send(8'h02); send(8'h03);
        for (int i = 0; i < 8; i++) send($urandom_range(0, 255));
        idle(12);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 255),
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 255));
        end
        idle(15);
        @(negedge clk);
        chk("pending_writes", 32'(exp_wr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/font_writer.md
FONT_WRITER -- requirements
Module: font_writer

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset; ports listed clock and reset first.
REQ-002 i_clk  input  1  system clock; all state changes on rising edge.
REQ-003 i_rst  input  1  synchronous active-high reset.
REQ-004 i_start  input  1  one-cycle request: begin loading glyph i_char at row 0.
REQ-005 i_char  input  8  target character code, sampled when i_start=1.
REQ-006 i_data  input  8  packed glyph byte.
REQ-007 i_valid  input  1  i_data valid; byte accepted when i_valid=1 and o_ready=1.
REQ-008 o_ready  output  1  byte can be accepted this cycle.
REQ-009 o_busy  output  1  state is not IDLE.
REQ-010 o_done  output  1  one-cycle pulse: all 64 entries of a glyph written.
REQ-011 o_we  output  1  glyph RAM write enable.
REQ-012 o_addr  output  14  glyph RAM address {char[7:0], row[2:0], column[2:0]}.
REQ-013 o_alpha  output  3  alpha value written.

Function
REQ-014 SHALL implement states IDLE, COLLECT, WRITE.
REQ-015 IDLE: o_ready=0; i_start latches i_char, clears row and byte count, enters COLLECT next cycle.
REQ-016 COLLECT: o_ready=1 (registered state decode); accepted bytes fill a 24-bit word little-endian: byte0 -> bits 7:0, byte1 -> 15:8, byte2 -> 23:16.
REQ-017 Third accepted byte of a row -> WRITE next cycle.
REQ-018 WRITE: o_ready=0; 8 consecutive cycles with o_we=1, column 0..7, o_alpha=word[3c+2:3c], o_addr={char,row,c}.
REQ-019 Latency: third byte accepted in cycle N -> writes in cycles N+1..N+8, no gaps.
REQ-020 After column 7 of rows 0..6: row+1, byte count 0, return to COLLECT.
REQ-021 After column 7 of row 7: o_done=1 in cycle N+9; next state per REQ-030/031.
REQ-022 i_start in COLLECT or WRITE SHALL abort: no further writes for old glyph, partial word discarded, new char latched, COLLECT at row 0 byte 0 next cycle.
REQ-023 i_start with an accepted byte in the same cycle: start wins, byte discarded, not counted.
REQ-024 i_valid while o_ready=0 SHALL be ignored (no side effects).
REQ-025 o_we=0 in every non-WRITE cycle; o_addr/o_alpha don't-care when o_we=0.

Reset
REQ-026 i_rst=1 SHALL force IDLE next cycle regardless of state, including mid-WRITE (no further writes).
REQ-027 Reset values: o_ready=0, o_busy=0, o_done=0, o_we=0, o_addr=0, o_alpha=0; char, row, column, byte count, word cleared.
REQ-028 i_rst SHALL take priority over i_start.

Configuration
REQ-029 Macro FONT_WRITER_AUTOINC_EN selects end-of-glyph behaviour.
REQ-030 Defined: after row 7, char+1 modulo 256 (0xFF->0x00), row 0, state COLLECT; o_done still pulses; stream continues without i_start.
REQ-031 Undefined: after row 7, state IDLE; new i_start required.

Structure
REQ-032 Shared package char_pkg SHALL hold GLYPH_ROWS=8, GLYPH_COLS=8, ALPHA_W=3, CHAR_W=8, FONT_ADDR_W=14, BYTES_PER_ROW=3 and the state enum; the glyph reader uses the same constants.
REQ-033 Single module; no sub-module; FSM, counters and word register are local.

Verification
REQ-034 Reset: assert i_rst 2 cycles -> all outputs 0, o_busy=0; i_valid ignored.
REQ-035 i_start char 0x41, bytes 0xFF,0xFF,0xFF -> 8 writes addr 0x1040..0x1047, alpha 7, o_ready low those 8 cycles.
REQ-036 i_start char 0x00, bytes 0x88,0xC6,0xFA -> addr 0x0000..0x0007 alpha 0,1,2,3,4,5,6,7.
REQ-037 i_start 0xFF, 24 bytes -> 64 writes, last addr 0x3FFF, o_done one cycle after; without macro IDLE; with macro next 3 bytes write 0x0000..0x0007.
REQ-038 i_start 0x10, 2 bytes, i_start 0x20 with i_valid=1 -> no writes to 0x04xx; next 3 bytes write 0x0800..0x0807.
REQ-039 i_rst after 3rd write of a row -> o_we=0 next cycle, IDLE, no o_done.
